ddr_note_lanes: RTL and testbench
=================================

# ddr_note_lanes

Note-lane engine for the DDR game. It spawns arrows into four lanes, scrolls them up one step per frame, and judges debounced button presses against the fixed target row. It also produces the per-pixel paint colour consumed by the display-colour/DE gating stage in the top level. It sits between the debounce and `simple_480p` outputs and the DVI output path, all in the pixel clock domain.

## Interface
Parameters:
- CORDW, 10: screen coordinate width
- V_RES, 480: vertical resolution; the spawn y-position
- LANE_X0, 192: left edge x of lane 0
- LANE_W, 64: lane width in pixels
- ARROW_H, 32: arrow and target-box height
- TARGET_Y, 48: top y of the target box
- SPEED, 2: pixels moved per frame
- SPAWN_FRAMES, 30: frames between spawns (≥1)
- WIN_PERFECT, 4: max \|y−TARGET_Y\| for PERFECT
- WIN_GOOD, 12: max \|y−TARGET_Y\| for GOOD
- LFSR_SEED, 8'hA5: LFSR reset value (nonzero)

Ports:
- clk_pix_i  in  1  pixel clock. One clock only.
- rst_pix_i  in  1  reset, synchronous, active-high
- frame_i  in  1  one-cycle pulse at the start of vblank
- sx_i, sy_i  in  CORDW  current pixel coordinates
- btn_i  in  4  debounced levels; bit0 left, bit1 up, bit2 down, bit3 right
- paint_r_o, paint_g_o, paint_b_o  out  4 each  pixel colour
- judge_valid_o  out  1  one-cycle judgement pulse
- judge_lane_o  out  2  lane of the judgement
- judge_o  out  2  judgement code: NONE=0, PERFECT=1, GOOD=2, MISS=3

## Operation
- Storage: each lane has 4 slots, each holding {valid, y[CORDW-1:0]}. y is the arrow's top edge.
- Edge detect: btn_prev is registered every cycle. A rise (btn_i & ~btn_prev) sets the lane's sticky pending bit. A rise on a lane whose pending bit is already set merges into it.
- States:
  - IDLE: if frame_i, go to SCAN with idx=0. Otherwise, if any pending bit is set, go to JUDGE. frame_i has priority.
  - SCAN: one slot per cycle, idx 0..15 (lane = idx[3:2]). A valid slot gets y ← y−SPEED. If the new y + WIN_GOOD < TARGET_Y, the slot is cleared and a MISS is emitted for that lane. Comparisons are widened to CORDW+1 bits with no underflow. After idx 15, go to SPAWN.
  - SPAWN: if frame_cnt == SPAWN_FRAMES−1:
    - frame_cnt ← 0
    - LFSR steps once (8-bit Galois, shift right, XOR 0xB8 when the shifted-out lsb is 1)
    - lane ← new lfsr[1:0]
    - the lowest-index free slot of that lane gets y=V_RES
    - if the lane has no free slot, the spawn is silently dropped
    
    Otherwise frame_cnt increments. Then go to IDLE.
  - JUDGE: take the lowest-numbered pending lane and clear its bit. Among that lane's valid slots, pick the one with the smallest \|y−TARGET_Y\| (lowest index on ties).
    - d ≤ WIN_PERFECT: PERFECT, slot cleared
    - d ≤ WIN_GOOD: GOOD, slot cleared
    - otherwise, or no valid slot: MISS, slots unchanged
    
    Return to IDLE.
- Rendering is combinational from sx_i, sy_i and the stored state. Priority order:
  - Note: arrow pixel when x ∈ [LANE_X0+lane·LANE_W+8, LANE_X0+(lane+1)·LANE_W−8) and sy_i ∈ [y, y+ARROW_H). Lane colours: 0 = F,2,2; 1 = 2,6,F; 2 = 2,F,2; 3 = F,F,2.
  - Target box: same x range, sy_i ∈ [TARGET_Y, TARGET_Y+ARROW_H). Colour is F,F,F while btn_i[lane] is held, else 8,8,8.
  - Background: 1,1,2.
- Reset values:
  - all slots invalid
  - state IDLE
  - frame_cnt 0
  - lfsr = LFSR_SEED
  - pending 0, btn_prev 0
  - judge_valid_o 0, judge_lane_o 0, judge_o NONE
- Reset mid-SCAN or mid-JUDGE abandons the operation. Any partial state is overwritten by the reset values.

## Timing
- Judgement outputs are registered. judge_valid_o is high for exactly one cycle per event, and lane/code are valid only while it is high.
- Press latency: btn_i rise sampled at edge k with the FSM in IDLE and no frame_i at k+1 → JUDGE at k+1 → judge_valid_o high after edge k+2.
- Frame: frame_i sampled at edge t in IDLE → SCAN for idx i at t+1+i → SPAWN at t+17 → IDLE at t+18. A MISS for slot i is visible after edge t+2+i.
- Presses arriving during SCAN or SPAWN stay pending and are judged from IDLE afterwards, one lane per two cycles.
- Paint has zero latency relative to sx_i/sy_i. Slot updates happen only in vblank (SCAN/SPAWN/JUDGE timing is independent of de; judging in the active area only changes state at cycle granularity).

## Structure
- Package ddr_pkg holds:
  - judge_t enum (NONE, PERFECT, GOOD, MISS)
  - lane indices
  - LANES=4, SLOTS=4
  - colour constants
  - the note-slot struct {valid, y}
- One sub-module, ddr_lfsr: 8-bit Galois LFSR with seed parameter, step enable and synchronous reset.

## Test plan
- Reset → judge_valid_o=0, judge_o=0. Paint at (0,0) = 1,1,2. Paint at (200,50) = 8,8,8, or F,F,F with btn_i[0]=1.
- SPAWN_FRAMES=1, seed A5: first frame → LFSR=0xEA, arrow in lane 2 at y=480. Paint at (330,480) is lane-2 green after a second frame moves it to 478.
- SPAWN_FRAMES=255, arrow spawned on frame 255, 216 further frames (y=48): btn_i[2] rise → PERFECT, lane 2, arrow no longer drawn.
- Same setup at y=56 (212 frames) → GOOD. At y=80 → MISS with the arrow still present.
- No press: arrow reaches y=34 (223 frames) → a single MISS pulse for lane 2 during SCAN, slot cleared.
- frame_i and a btn_i[1] rise on the same cycle → SCAN and SPAWN complete first, then the lane-1 judgement pulse follows at t+20.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and constants for the DDR note-lane engine.
package ddr_pkg;

  localparam int unsigned LANES = 4;
  localparam int unsigned SLOTS = 4;
  localparam int unsigned Y_W   = 10;

  localparam logic [1:0] LANE_LEFT  = 2'd0;
  localparam logic [1:0] LANE_UP    = 2'd1;
  localparam logic [1:0] LANE_DOWN  = 2'd2;
  localparam logic [1:0] LANE_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    J_NONE    = 2'd0,
    J_PERFECT = 2'd1,
    J_GOOD    = 2'd2,
    J_MISS    = 2'd3
  } judge_t;

  typedef struct packed {
    logic           valid;
    logic [Y_W-1:0] y;
  } slot_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t COL_BG      = rgb_t'(12'h112);
  localparam rgb_t COL_TGT_OFF = rgb_t'(12'h888);
  localparam rgb_t COL_TGT_ON  = rgb_t'(12'hFFF);

  function automatic rgb_t lane_colour(input logic [1:0] lane);
    rgb_t c;
    case (lane)
      LANE_LEFT:  c = rgb_t'(12'hF22);
      LANE_UP:    c = rgb_t'(12'h26F);
      LANE_DOWN:  c = rgb_t'(12'h2F2);
      LANE_RIGHT: c = rgb_t'(12'hFF2);
      default:    c = COL_BG;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ddr_lfsr.sv
// 8-bit Galois LFSR (shift right, taps 0xB8); exposes the low bits of the post-step value.
module ddr_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       step_i,
  output logic [1:0] lane_c
);

  logic [7:0] lfsr_q, lfsr_d, stepped;

  assign stepped = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
  assign lfsr_d  = step_i ? stepped : lfsr_q;
  assign lane_c  = stepped[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/ddr_note_lanes.sv
// Note-lane engine: spawns and scrolls arrows once per frame, judges presses
// against the target row, and paints the playfield combinationally.
module ddr_note_lanes
  import ddr_pkg::*;
#(
  parameter int unsigned CORDW        = 10,
  parameter int unsigned V_RES        = 480,
  parameter int unsigned LANE_X0      = 192,
  parameter int unsigned LANE_W       = 64,
  parameter int unsigned ARROW_H      = 32,
  parameter int unsigned TARGET_Y     = 48,
  parameter int unsigned SPEED        = 2,
  parameter int unsigned SPAWN_FRAMES = 30,
  parameter int unsigned WIN_PERFECT  = 4,
  parameter int unsigned WIN_GOOD     = 12,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic             clk_pix_i,
  input  logic             rst_pix_i,
  input  logic             frame_i,
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  input  logic [3:0]       btn_i,
  output logic [3:0]       paint_r_o,
  output logic [3:0]       paint_g_o,
  output logic [3:0]       paint_b_o,
  output logic             judge_valid_o,
  output logic [1:0]       judge_lane_o,
  output logic [1:0]       judge_o
);

  localparam int unsigned CNT_W = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int unsigned D_W   = Y_W + 1;
  localparam int unsigned NSLOT = LANES * SLOTS;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SPAWN, S_JUDGE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  slot_t            slots_q [NSLOT];
  slot_t            slots_d [NSLOT];
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [3:0]       pending_q, pending_d, pend_clr, btn_prev_q;
  logic             frame_pend_q, frame_pend_d, frame_take;
  logic             judge_valid_q, judge_valid_d;
  logic [1:0]       judge_lane_q, judge_lane_d;
  judge_t           judge_q, judge_d;

  logic             lfsr_step;
  logic [1:0]       spawn_lane, spawn_slot, jlane, best_slot;
  logic             spawn_free, jfound, best_found, scan_miss;
  logic [D_W-1:0]   best_dist, cand_dist;
  logic [31:0]      sx_w, sy_w;
  rgb_t             paint_c;

  function automatic logic [D_W-1:0] target_dist(input logic [Y_W-1:0] y);
    logic [D_W-1:0] yw, tw;
    yw = D_W'(y);
    tw = D_W'(TARGET_Y);
    return (yw >= tw) ? yw - tw : tw - yw;
  endfunction

  ddr_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk_i  (clk_pix_i),
    .rst_i  (rst_pix_i),
    .step_i (lfsr_step),
    .lane_c (spawn_lane)
  );

  // Widened compare so a slot near the top can never wrap around.
  assign scan_miss = (D_W'(slots_q[idx_q].y) + D_W'(WIN_GOOD)) < (D_W'(TARGET_Y) + D_W'(SPEED));

  always_comb begin : spawn_pick
    spawn_free = 1'b0;
    spawn_slot = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      if (!spawn_free && !slots_q[{spawn_lane, 2'(s)}].valid) begin
        spawn_free = 1'b1;
        spawn_slot = 2'(s);
      end
    end
  end

  // Lowest pending lane, then its closest valid slot (lowest index wins ties).
  always_comb begin : judge_pick
    jfound = 1'b0;
    jlane  = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (!jfound && pending_q[2'(l)]) begin
        jfound = 1'b1;
        jlane  = 2'(l);
      end
    end
    best_found = 1'b0;
    best_slot  = '0;
    best_dist  = '1;
    cand_dist  = '0;
    for (int unsigned s = 0; s < SLOTS; s++) begin
      cand_dist = target_dist(slots_q[{jlane, 2'(s)}].y);
      if (slots_q[{jlane, 2'(s)}].valid && (!best_found || cand_dist < best_dist)) begin
        best_found = 1'b1;
        best_slot  = 2'(s);
        best_dist  = cand_dist;
      end
    end
  end

  always_comb begin : fsm_next
    state_d       = state_q;
    idx_d         = idx_q;
    slots_d       = slots_q;
    frame_cnt_d   = frame_cnt_q;
    lfsr_step     = 1'b0;
    pend_clr      = '0;
    frame_take    = 1'b0;
    judge_valid_d = 1'b0;
    judge_lane_d  = '0;
    judge_d       = J_NONE;
    unique case (state_q)
      S_IDLE: begin
        if (frame_pend_q) begin
          state_d    = S_SCAN;
          idx_d      = '0;
          frame_take = 1'b1;
        end else if (|pending_q) begin
          state_d = S_JUDGE;
        end
      end
      S_SCAN: begin
        if (slots_q[idx_q].valid) begin
          if (scan_miss) begin
            slots_d[idx_q].valid = 1'b0;
            judge_valid_d        = 1'b1;
            judge_lane_d         = idx_q[3:2];
            judge_d              = J_MISS;
          end else begin
            slots_d[idx_q].y = slots_q[idx_q].y - Y_W'(SPEED);
          end
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == 4'd15) state_d = S_SPAWN;
      end
      S_SPAWN: begin
        if (frame_cnt_q == CNT_W'(SPAWN_FRAMES - 1)) begin
          frame_cnt_d = '0;
          lfsr_step   = 1'b1;
          if (spawn_free) begin
            slots_d[{spawn_lane, spawn_slot}].valid = 1'b1;
            slots_d[{spawn_lane, spawn_slot}].y     = Y_W'(V_RES);
          end
        end else begin
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end
        state_d = S_IDLE;
      end
      S_JUDGE: begin
        pend_clr[jlane] = 1'b1;
        judge_valid_d   = 1'b1;
        judge_lane_d    = jlane;
        if (best_found && best_dist <= D_W'(WIN_PERFECT)) begin
          judge_d                              = J_PERFECT;
          slots_d[{jlane, best_slot}].valid    = 1'b0;
        end else if (best_found && best_dist <= D_W'(WIN_GOOD)) begin
          judge_d                              = J_GOOD;
          slots_d[{jlane, best_slot}].valid    = 1'b0;
        end else begin
          judge_d = J_MISS;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    pending_d    = (pending_q & ~pend_clr) | (btn_i & ~btn_prev_q);
    frame_pend_d = (frame_pend_q & ~frame_take) | frame_i;
  end

  always_ff @(posedge clk_pix_i) begin
    if (rst_pix_i) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      slots_q       <= '{default: '0};
      frame_cnt_q   <= '0;
      pending_q     <= '0;
      btn_prev_q    <= '0;
      frame_pend_q  <= 1'b0;
      judge_valid_q <= 1'b0;
      judge_lane_q  <= '0;
      judge_q       <= J_NONE;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      slots_q       <= slots_d;
      frame_cnt_q   <= frame_cnt_d;
      pending_q     <= pending_d;
      btn_prev_q    <= btn_i;
      frame_pend_q  <= frame_pend_d;
      judge_valid_q <= judge_valid_d;
      judge_lane_q  <= judge_lane_d;
      judge_q       <= judge_d;
    end
  end

  assign sx_w = 32'(sx_i);
  assign sy_w = 32'(sy_i);

  // Later assignments win: notes override the target box, which overrides background.
  always_comb begin : render
    paint_c = COL_BG;
    for (int unsigned l = 0; l < LANES; l++) begin
      if (sx_w >= LANE_X0 + l * LANE_W + 8 && sx_w < LANE_X0 + (l + 1) * LANE_W - 8) begin
        if (sy_w >= TARGET_Y && sy_w < TARGET_Y + ARROW_H)
          paint_c = btn_i[2'(l)] ? COL_TGT_ON : COL_TGT_OFF;
        for (int unsigned s = 0; s < SLOTS; s++) begin
          if (slots_q[4'(l * SLOTS + s)].valid &&
              sy_w >= 32'(slots_q[4'(l * SLOTS + s)].y) &&
              sy_w <  32'(slots_q[4'(l * SLOTS + s)].y) + ARROW_H)
            paint_c = lane_colour(2'(l));
        end
      end
    end
  end

  assign paint_r_o     = paint_c.r;
  assign paint_g_o     = paint_c.g;
  assign paint_b_o     = paint_c.b;
  assign judge_valid_o = judge_valid_q;
  assign judge_lane_o  = judge_lane_q;
  assign judge_o       = judge_q;

endmodule

// File: tb/tb_ddr_note_lanes.sv
// Directed bench for ddr_note_lanes: spawn, scroll, judging windows, timing and paint.
module tb_ddr_note_lanes;

  logic       clk_pix_i = 1'b0;
  logic       rst_pix_i = 1'b1;
  logic       frame_i   = 1'b0;
  logic [9:0] sx_i      = '0;
  logic [9:0] sy_i      = '0;
  logic [3:0] btn_i     = '0;
  logic [3:0] paint_r_o, paint_g_o, paint_b_o;
  logic       judge_valid_o;
  logic [1:0] judge_lane_o, judge_o;

  int n_checks = 0;
  int n_fail   = 0;
  int jtot     = 0;
  logic [1:0] jlane_last = '0;
  logic [1:0] jcode_last = '0;

  ddr_note_lanes #(.SPAWN_FRAMES(255)) u_dut (
    .clk_pix_i     (clk_pix_i),
    .rst_pix_i     (rst_pix_i),
    .frame_i       (frame_i),
    .sx_i          (sx_i),
    .sy_i          (sy_i),
    .btn_i         (btn_i),
    .paint_r_o     (paint_r_o),
    .paint_g_o     (paint_g_o),
    .paint_b_o     (paint_b_o),
    .judge_valid_o (judge_valid_o),
    .judge_lane_o  (judge_lane_o),
    .judge_o       (judge_o)
  );

  always #5 clk_pix_i = ~clk_pix_i;

  // Tally judgement pulses away from the active edge.
  always @(negedge clk_pix_i) begin
    if (judge_valid_o === 1'b1) begin
      jtot++;
      jlane_last = judge_lane_o;
      jcode_last = judge_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_pix_i);
    #1;
  endtask

  task automatic do_reset();
    rst_pix_i = 1'b1; frame_i = 1'b0; btn_i = '0; sx_i = '0; sy_i = '0;
    tick(3);
    rst_pix_i = 1'b0;
    tick(1);
  endtask

  task automatic do_frames(input int n);
    repeat (n) begin
      frame_i = 1'b1; tick(1);
      frame_i = 1'b0; tick(19);
    end
  endtask

  task automatic set_pix(input int x, input int y);
    sx_i = 10'(x); sy_i = 10'(y); #1;
  endtask

  task automatic arrange(input int after_spawn);
    do_reset();
    do_frames(255 + after_spawn);
  endtask

  task automatic test_reset();
    logic [2:0] vld;
    do_reset();
    n_checks++; if (judge_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", judge_valid_o); end
    n_checks++; if (judge_o !== 2'd0) begin n_fail++; $display("FAIL reset_code got %0d want 0", judge_o); end
    set_pix(0, 0);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h112) begin n_fail++; $display("FAIL reset_bg got %h want 112", {paint_r_o, paint_g_o, paint_b_o}); end
    set_pix(200, 50);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h888) begin n_fail++; $display("FAIL target_off got %h want 888", {paint_r_o, paint_g_o, paint_b_o}); end
    btn_i = 4'b0001; #1;
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'hFFF) begin n_fail++; $display("FAIL target_on got %h want fff", {paint_r_o, paint_g_o, paint_b_o}); end
    for (int m = 0; m < 3; m++) begin
      @(posedge clk_pix_i); @(negedge clk_pix_i);
      vld[m] = judge_valid_o;
    end
    n_checks++; if (vld !== 3'b100) begin n_fail++; $display("FAIL press_latency got %b want 100", vld); end
    n_checks++; if (judge_lane_o !== 2'd0 || judge_o !== 2'd3) begin n_fail++; $display("FAIL empty_lane_miss got lane %0d code %0d want lane 0 code 3", judge_lane_o, judge_o); end
    btn_i = '0; tick(3);
  endtask

  task automatic test_spawn();
    int px [7];
    int py [7];
    logic [11:0] ex [7];
    int j0;
    do_reset();
    j0 = jtot;
    do_frames(254);
    set_pix(330, 480);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h112) begin n_fail++; $display("FAIL no_spawn_yet got %h want 112", {paint_r_o, paint_g_o, paint_b_o}); end
    do_frames(1);
    set_pix(330, 480);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h2F2) begin n_fail++; $display("FAIL spawn_lane2 got %h want 2f2", {paint_r_o, paint_g_o, paint_b_o}); end
    do_frames(1);
    px = '{330, 330, 330, 327, 375, 376, 200};
    py = '{478, 509, 477, 478, 478, 478, 478};
    ex = '{12'h2F2, 12'h2F2, 12'h112, 12'h112, 12'h2F2, 12'h112, 12'h112};
    for (int i = 0; i < 7; i++) begin
      set_pix(px[i], py[i]);
      n_checks++;
      if ({paint_r_o, paint_g_o, paint_b_o} !== ex[i]) begin
        n_fail++; $display("FAIL scroll_paint(%0d,%0d) got %h want %h", px[i], py[i], {paint_r_o, paint_g_o, paint_b_o}, ex[i]);
      end
    end
    n_checks++; if (jtot - j0 !== 0) begin n_fail++; $display("FAIL spurious_judge got %0d want 0", jtot - j0); end
  endtask

  task automatic test_perfect();
    int j0;
    arrange(216);
    set_pix(330, 48);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h2F2) begin n_fail++; $display("FAIL arrow_at_48 got %h want 2f2", {paint_r_o, paint_g_o, paint_b_o}); end
    j0 = jtot; btn_i = 4'b0100; tick(4);
    n_checks++; if (jtot - j0 !== 1 || jlane_last !== 2'd2 || jcode_last !== 2'd1) begin n_fail++; $display("FAIL perfect got n=%0d lane %0d code %0d want n=1 lane 2 code 1", jtot - j0, jlane_last, jcode_last); end
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'hFFF) begin n_fail++; $display("FAIL perfect_cleared got %h want fff", {paint_r_o, paint_g_o, paint_b_o}); end
    btn_i = '0; tick(1);
  endtask

  task automatic test_good();
    int j0;
    arrange(212);
    set_pix(330, 56);
    j0 = jtot; btn_i = 4'b0100; tick(4);
    n_checks++; if (jtot - j0 !== 1 || jlane_last !== 2'd2 || jcode_last !== 2'd2) begin n_fail++; $display("FAIL good got n=%0d lane %0d code %0d want n=1 lane 2 code 2", jtot - j0, jlane_last, jcode_last); end
    btn_i = '0; tick(1);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h888) begin n_fail++; $display("FAIL good_cleared got %h want 888", {paint_r_o, paint_g_o, paint_b_o}); end
  endtask

  task automatic test_late();
    int j0;
    arrange(200);
    set_pix(330, 80);
    j0 = jtot; btn_i = 4'b0100; tick(4);
    n_checks++; if (jtot - j0 !== 1 || jlane_last !== 2'd2 || jcode_last !== 2'd3) begin n_fail++; $display("FAIL late_miss got n=%0d lane %0d code %0d want n=1 lane 2 code 3", jtot - j0, jlane_last, jcode_last); end
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h2F2) begin n_fail++; $display("FAIL late_kept got %h want 2f2", {paint_r_o, paint_g_o, paint_b_o}); end
    btn_i = '0; tick(1);
  endtask

  task automatic test_no_press();
    int j0;
    arrange(222);
    set_pix(330, 36);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h2F2) begin n_fail++; $display("FAIL arrow_at_36 got %h want 2f2", {paint_r_o, paint_g_o, paint_b_o}); end
    j0 = jtot;
    do_frames(1);
    n_checks++; if (jtot - j0 !== 1 || jlane_last !== 2'd2 || jcode_last !== 2'd3) begin n_fail++; $display("FAIL scan_miss got n=%0d lane %0d code %0d want n=1 lane 2 code 3", jtot - j0, jlane_last, jcode_last); end
    set_pix(330, 50);
    n_checks++; if ({paint_r_o, paint_g_o, paint_b_o} !== 12'h888) begin n_fail++; $display("FAIL scan_cleared got %h want 888", {paint_r_o, paint_g_o, paint_b_o}); end
  endtask

  task automatic test_two_lanes();
    logic [6:0] vld;
    logic [1:0] ln [7];
    do_reset();
    btn_i = 4'b1001;
    for (int m = 0; m < 7; m++) begin
      @(negedge clk_pix_i);
      vld[m] = judge_valid_o; ln[m] = judge_lane_o;
    end
    n_checks++; if (vld !== 7'b0101000) begin n_fail++; $display("FAIL two_lane_pulses got %b want 0101000", vld); end
    n_checks++; if (ln[3] !== 2'd0 || ln[5] !== 2'd3) begin n_fail++; $display("FAIL two_lane_order got %0d,%0d want 0,3", ln[3], ln[5]); end
    btn_i = '0; tick(2);
  endtask

  task automatic test_back_to_back();
    int first;
    int pulses;
    logic [1:0] fl, fc;
    do_reset();
    first = -1; pulses = 0; fl = '0; fc = '0;
    frame_i = 1'b1; btn_i = 4'b0010;
    @(posedge clk_pix_i); #1;
    frame_i = 1'b0;
    for (int m = 0; m < 24; m++) begin
      @(negedge clk_pix_i);
      if (judge_valid_o === 1'b1) begin
        pulses++;
        if (first < 0) begin first = m; fl = judge_lane_o; fc = judge_o; end
      end
    end
    n_checks++; if (first !== 20) begin n_fail++; $display("FAIL frame_then_judge_cycle got %0d want 20", first); end
    n_checks++; if (pulses !== 1 || fl !== 2'd1 || fc !== 2'd3) begin n_fail++; $display("FAIL frame_then_judge got n=%0d lane %0d code %0d want n=1 lane 1 code 3", pulses, fl, fc); end
    btn_i = '0; tick(2);
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_perfect();
    test_good();
    test_late();
    test_no_press();
    test_two_lanes();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
